alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 39 +++
 rtl/alu.sv | 41 ++++
 rtl/alu_rr_pick.sv | 32 +++
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode constants,
// sequencer state encoding, lock-streak default and the carry-update rule.
package alu_arb_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBB = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_TRAN = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;

  // Default cap on consecutive grants to one requester while it holds a lock
  localparam int LOCK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Next value of a requester's carry register after executing opcode
  function automatic logic carry_next(input logic [3:0] opcode,
                                      input logic       res_bit8,
                                      input logic       c_old);
    case (opcode)
      OP_ADDC, OP_SUBB, OP_DEC, OP_INC:                   carry_next = res_bit8;
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR:      carry_next = c_old;
      default:                                            carry_next = 1'b0; // ADD, SUB, illegal
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU datapath with 16-bit result and zero flag.
// Operands are zero-extended; TRAN and opcodes 13-15 yield res=0, z=0.
module alu
  import alu_arb_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [7:0]  opd_1,
  input  logic [7:0]  opd_2,
  output logic [15:0] res,
  output logic        z
);

  logic [15:0] a;
  logic [15:0] b;
  logic        legal;

  assign a = {8'h00, opd_1};
  assign b = {8'h00, opd_2};

  // Result and zero flag for the current opcode
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    res   = '0;
    legal = 1'b1;
    case (opcode)
      OP_ADD, OP_ADDC: res = a + b;
      OP_SUB, OP_SUBB: res = a - b;
      OP_DEC:          res = a - 16'd1;
      OP_INC:          res = a + 16'd1;
      OP_AND:          res = a & b;
      OP_OR:           res = a | b;
      OP_XOR:          res = a ^ b;
      OP_NOT:          res = ~a;
      OP_SHL:          res = a << 1;
      OP_SHR:          res = a >> 1;
      default:         legal = 1'b0;
    endcase
    z = legal && (res == 16'h0000);
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker with lock override and a streak limit.
// The streak count belongs to the last granted requester; once it reaches
// LOCK_MAX the other requester wins a tie even against a pending lock.
module alu_rr_pick
  import alu_arb_pkg::*;
#(
  parameter  int LOCK_MAX = LOCK_MAX_DEF,
  localparam int CNT_W    = $clog2(LOCK_MAX + 1)
) (
  input  logic [1:0]       valid,
  input  logic             last_gnt,
  input  logic             lock_pend,
  input  logic             lock_id,
  input  logic [CNT_W-1:0] streak,
  output logic             gnt_valid,
  output logic             gnt_id
);

  // Choose a requester: sole valid one wins, ties use limit, lock, then round-robin
  always_comb begin
    gnt_valid = |valid;
    gnt_id    = 1'b0;
    if (valid == 2'b10) begin
      gnt_id = 1'b1;
    end else if (valid == 2'b11) begin
      if (int'(streak) >= LOCK_MAX) gnt_id = ~last_gnt;
      else if (lock_pend)           gnt_id = lock_id;
      else                          gnt_id = ~last_gnt;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter and sequencer sharing one ALU between two requesters.
// IDLE/RESP accept a request, EXEC runs it, RESP presents the response.
// Optional lock/streak arbitration is enabled with macro ALU_ARB_LOCK_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [7:0]  req0_opd_1,
  input  logic [7:0]  req0_opd_2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opcode,
  input  logic [7:0]  req1_opd_1,
  input  logic [7:0]  req1_opd_2,
`ifdef ALU_ARB_LOCK_EN
  input  logic        req0_lock,
  input  logic        req1_lock,
`endif
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_res,
  output logic        rsp_c,
  output logic        rsp_z
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_t           state;
  logic [3:0]       op_code_q;
  logic [7:0]       op_a_q;
  logic [7:0]       op_b_q;
  logic             op_id_q;
  logic [1:0]       c_q;
  logic             last_gnt;

  logic             accepting;
  logic             gnt_valid;
  logic             gnt_id;
  logic             hs;
  logic [3:0]       sel_opcode;
  logic [7:0]       sel_a;
  logic [7:0]       sel_b;
  logic [15:0]      alu_res;
  logic             alu_z;
  logic             c_new;
  logic [CNT_W-1:0] streak_cnt;
  logic             lock_pend;
  logic             lock_id;

  assign accepting  = (state != EXEC);
  assign hs         = accepting && gnt_valid;
  assign req0_ready = hs && !gnt_id;
  assign req1_ready = hs &&  gnt_id;

  assign sel_opcode = gnt_id ? req1_opcode : req0_opcode;
  assign sel_a      = gnt_id ? req1_opd_1  : req0_opd_1;
  assign sel_b      = gnt_id ? req1_opd_2  : req0_opd_2;

  alu_rr_pick #(.LOCK_MAX(LOCK_MAX)) u_pick (
    .valid     ({req1_valid, req0_valid}),
    .last_gnt  (last_gnt),
    .lock_pend (lock_pend),
    .lock_id   (lock_id),
    .streak    (streak_cnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  alu u_alu (
    .opcode (op_code_q),
    .opd_1  (op_a_q),
    .opd_2  (op_b_q),
    .res    (alu_res),
    .z      (alu_z)
  );

  assign c_new = carry_next(op_code_q, alu_res[8], c_q[op_id_q]);

  // Sequencer: capture granted request, execute, register the response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_code_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_id_q   <= 1'b0;
      // NOTE: the carry registers are only two flops, so they take the reset like any control state.
      c_q       <= '0;
      last_gnt  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_c     <= 1'b0;
      rsp_z     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rsp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (hs) begin
            op_code_q <= sel_opcode;
            op_a_q    <= sel_a;
            op_b_q    <= sel_b;
            op_id_q   <= gnt_id;
            last_gnt  <= gnt_id;
            state     <= EXEC;
          end else begin
            state     <= IDLE;
          end
        end
        EXEC: begin
          rsp_valid      <= 1'b1;
          rsp_id         <= op_id_q;
          rsp_res        <= alu_res;
          rsp_z          <= alu_z;
          rsp_c          <= c_new;
          c_q[op_id_q]   <= c_new;
          state          <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_LOCK_EN
  logic sel_lock;
  assign sel_lock = gnt_id ? req1_lock : req0_lock;

  // Lock and streak bookkeeping, updated on every accepting cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_cnt <= '0;
      lock_pend  <= 1'b0;
      lock_id    <= 1'b0;
    end else if (accepting) begin
      if (hs) begin
        if (gnt_id == last_gnt)
          streak_cnt <= (streak_cnt < CNT_W'(LOCK_MAX)) ? streak_cnt + 1'b1 : streak_cnt;
        else
          streak_cnt <= CNT_W'(1);
        lock_pend <= sel_lock;
        lock_id   <= gnt_id;
      end else begin
        streak_cnt <= '0;
        lock_pend  <= 1'b0;
      end
    end
  end
`else
  assign streak_cnt = '0;
  assign lock_pend  = 1'b0;
  assign lock_id    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a spec-level model checks readies and
// responses every cycle, directed sequences pin hand-computed values.
module tb_alu_arbiter;

  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode = '0, req1_opcode = '0;
  logic [7:0]  req0_opd_1 = '0, req0_opd_2 = '0, req1_opd_1 = '0, req1_opd_2 = '0;
  logic        req0_lock = 1'b0, req1_lock = 1'b0;
  logic        rsp_valid, rsp_id, rsp_c, rsp_z;
  logic [15:0] rsp_res;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opcode (req0_opcode),
    .req0_opd_1  (req0_opd_1),
    .req0_opd_2  (req0_opd_2),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opcode (req1_opcode),
    .req1_opd_1  (req1_opd_1),
    .req1_opd_2  (req1_opd_2),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock   (req0_lock),
    .req1_lock   (req1_lock),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_res     (rsp_res),
    .rsp_c       (rsp_c),
    .rsp_z       (rsp_z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    bit id;
    int res;
    bit c;
    bit z;
  } exp_t;

  function automatic exp_t model_op(input bit id, input int op, input int a, input int b,
                                    input bit c_old);
    exp_t e;
    int   r;
    bit   legal = 1'b1;
    case (op)
      0, 1:    r = a + b;
      2, 3:    r = a - b;
      4:       r = a - 1;
      5:       r = a + 1;
      7:       r = a & b;
      8:       r = a | b;
      9:       r = a ^ b;
      10:      r = ~a;
      11:      r = a * 2;
      12:      r = a / 2;
      default: begin r = 0; legal = 1'b0; end
    endcase
    r = r & 32'hFFFF;
    e.v   = 1'b1;
    e.id  = id;
    e.res = r;
    e.z   = legal && (r == 0);
    case (op)
      1, 3, 4, 5:             e.c = ((r >> 8) & 1) != 0;
      7, 8, 9, 10, 11, 12:    e.c = c_old;
      default:                e.c = 1'b0;
    endcase
    return e;
  endfunction

  exp_t p1, p2;
  bit   m_last = 1'b1;
  bit   m_busy = 1'b0;
  bit   m_c[2];
  bit   m_lock_pend = 1'b0;
  bit   m_lock_id = 1'b0;
  int   m_streak = 0;

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (reset) begin
      m_last = 1'b1; m_busy = 1'b0; m_c[0] = 1'b0; m_c[1] = 1'b0;
      p1 = '{default: 0}; p2 = '{default: 0};
      m_lock_pend = 1'b0; m_lock_id = 1'b0; m_streak = 0;
      check("mdl_rsp_valid_in_reset", rsp_valid, 0);
    end else begin
      bit   any, gid, e0, e1;
      exp_t e;
      check("mdl_rsp_valid", rsp_valid, p2.v);
      if (p2.v) begin
        check("mdl_rsp_id", rsp_id, p2.id);
        check("mdl_rsp_res", rsp_res, p2.res);
        check("mdl_rsp_c", rsp_c, p2.c);
        check("mdl_rsp_z", rsp_z, p2.z);
      end
      any = !m_busy && (req0_valid || req1_valid);
      gid = 1'b0;
      if (req1_valid && !req0_valid) gid = 1'b1;
      else if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_LOCK_EN
        if (m_streak >= LOCK_MAX) gid = !m_last;
        else if (m_lock_pend)     gid = m_lock_id;
        else                      gid = !m_last;
`else
        gid = !m_last;
`endif
      end
      e0 = any && !gid;
      e1 = any && gid;
      check("mdl_req0_ready", req0_ready, e0);
      check("mdl_req1_ready", req1_ready, e1);
      p2 = p1;
      p1 = '{default: 0};
      if (any) begin
        if (gid) e = model_op(1'b1, req1_opcode, req1_opd_1, req1_opd_2, m_c[1]);
        else     e = model_op(1'b0, req0_opcode, req0_opd_1, req0_opd_2, m_c[0]);
        p1 = e;
        m_c[gid] = e.c;
`ifdef ALU_ARB_LOCK_EN
        if (gid == m_last) m_streak = (m_streak < LOCK_MAX) ? m_streak + 1 : m_streak;
        else               m_streak = 1;
        m_lock_pend = gid ? req1_lock : req0_lock;
        m_lock_id   = gid;
`endif
        m_last = gid;
        m_busy = 1'b1;
      end else begin
        if (!m_busy) begin
          m_streak = 0;
          m_lock_pend = 1'b0;
        end
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit id, input bit v, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    if (!id) begin
      req0_valid = v; req0_opcode = op; req0_opd_1 = a; req0_opd_2 = b;
    end else begin
      req1_valid = v; req1_opcode = op; req1_opd_1 = a; req1_opd_2 = b;
    end
  endtask

  task automatic issue(input bit id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int waits);
    bit got = 1'b0;
    waits = 0;
    @(posedge clk); #1;
    drive(id, 1'b1, op, a, b);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if ((!id && req0_ready) || (id && req1_ready)) begin
        got = 1'b1; waits = i; break;
      end
    end
    @(posedge clk); #1;
    drive(id, 1'b0, op, a, b);
    if (!got) check("handshake_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int lat, output logic [15:0] res, output logic id,
                          output logic c, output logic z);
    bit got = 1'b0;
    lat = 0; res = 'x; id = 'x; c = 'x; z = 'x;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; lat = i; res = rsp_res; id = rsp_id; c = rsp_c; z = rsp_z; break;
      end
    end
    if (!got) check("response_timeout", 0, 1);
  endtask

  task automatic op_check(input string name, input bit id, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] x_res, input bit x_c, input bit x_z);
    int w, lat;
    logic [15:0] r;
    logic rid, rc, rz;
    issue(id, op, a, b, w);
    wait_rsp(lat, r, rid, rc, rz);
    check({name, "_hs_wait"}, w, 1);
    check({name, "_latency"}, lat, 2);
    check({name, "_id"}, rid, id);
    check({name, "_res"}, r, x_res);
    check({name, "_c"}, rc, x_c);
    check({name, "_z"}, rz, x_z);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g[8];
    int          ng;
    logic [15:0] rr[8];
    logic        rc[8];
    int          nr;
    int          w;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_res", rsp_res, 0);
    check("rst_rsp_c", rsp_c, 0);
    check("rst_rsp_z", rsp_z, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Basic add, then carry set and held through a logic op
    op_check("add0", 1'b0, 4'd0, 8'h03, 8'h05, 16'h0008, 1'b0, 1'b0);
    op_check("addc1", 1'b1, 4'd1, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0);
    op_check("and1", 1'b1, 4'd7, 8'h0F, 8'hF0, 16'h0000, 1'b1, 1'b1);

    // Both requesters valid: grants alternate, one op per two cycles
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'd2, 8'h03, 8'h05);
    drive(1'b1, 1'b1, 4'd4, 8'h00, 8'h00);
    ng = 0; nr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req0_ready)      begin g[ng] = 0; ng++; end
      else if (req1_ready) begin g[ng] = 1; ng++; end
      if (rsp_valid) begin rr[nr] = rsp_res; rc[nr] = rsp_c; nr++; end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    check("alt_grant_count", ng, 4);
    check("alt_grant0", g[0], 0);
    check("alt_grant1", g[1], 1);
    check("alt_grant2", g[2], 0);
    check("alt_grant3", g[3], 1);
    check("alt_rsp_count", nr, 3);
    check("alt_rsp0_res", rr[0], 16'hFFFE);
    check("alt_rsp0_c", rc[0], 0);
    check("alt_rsp1_res", rr[1], 16'hFFFF);
    check("alt_rsp1_c", rc[1], 1);
    repeat (3) @(negedge clk);

    // Illegal opcodes clear carry; shifts keep bit 8 and hold carry
    op_check("inc0_a", 1'b0, 4'd5, 8'hFF, 8'h00, 16'h0100, 1'b1, 1'b0);
    op_check("tran0", 1'b0, 4'd6, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0);
    op_check("inc0_b", 1'b0, 4'd5, 8'hFF, 8'h00, 16'h0100, 1'b1, 1'b0);
    op_check("ill14", 1'b0, 4'd14, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
    op_check("shl0", 1'b0, 4'd11, 8'h81, 8'h00, 16'h0102, 1'b0, 1'b0);
    op_check("shr0", 1'b0, 4'd12, 8'h01, 8'h00, 16'h0000, 1'b0, 1'b1);

    // Reset while an op is in EXEC discards it
    issue(1'b0, 4'd0, 8'h01, 8'h01, w);
    reset = 1'b1;
    @(negedge clk);
    check("exec_rst_rsp_valid", rsp_valid, 0);
    check("exec_rst_rsp_res", rsp_res, 0);
    check("exec_rst_rsp_id", rsp_id, 0);
    check("exec_rst_rsp_c", rsp_c, 0);
    check("exec_rst_rsp_z", rsp_z, 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", rsp_valid, 0);
    end
    op_check("add1_after_rst", 1'b1, 4'd0, 8'h10, 8'h20, 16'h0030, 1'b0, 1'b0);

`ifdef ALU_ARB_LOCK_EN
    // Lock: req0 wins LOCK_MAX times, then req1, then req0 again
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'd0, 8'h01, 8'h02);
    drive(1'b1, 1'b1, 4'd0, 8'h03, 8'h04);
    req0_lock = 1'b1;
    req1_lock = 1'b0;
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready)      begin g[ng % 8] = 0; ng++; end
      else if (req1_ready) begin g[ng % 8] = 1; ng++; end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    req0_lock = 1'b0;
    check("lock_grant_count", ng, 6);
    check("lock_grant0", g[0], 0);
    check("lock_grant1", g[1], 0);
    check("lock_grant2", g[2], 0);
    check("lock_grant3", g[3], 0);
    check("lock_grant4", g[4], 1);
    check("lock_grant5", g[5], 0);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
